// File: rtl/player_bullet_if.sv
// Bus bundle around the player bullet pool: fire/player/fly inputs from the game logic and
// the flat bullet buses consumed by the renderer and the enemy controller.
interface player_bullet_if #(
    parameter int BULLET_COUNT = 8,
    parameter int FLY_COUNT    = 4
);
    logic                          fire;
    logic [9:0]                    player_x;
    logic [9:0]                    player_y;
    logic [10*FLY_COUNT-1:0]       fly_x_flat;
    logic [10*FLY_COUNT-1:0]       fly_y_flat;
    logic [FLY_COUNT-1:0]          fly_alive;
    logic [10*BULLET_COUNT-1:0]    bullet_x_flat;
    logic [10*BULLET_COUNT-1:0]    bullet_y_flat;
    logic [BULLET_COUNT-1:0]       bullet_active_flat;
    logic                          shot_fired;
    logic                          fire_dropped;

    modport master (
        output fire, player_x, player_y, fly_x_flat, fly_y_flat, fly_alive,
        input  bullet_x_flat, bullet_y_flat, bullet_active_flat, shot_fired, fire_dropped
    );

    modport slave (
        input  fire, player_x, player_y, fly_x_flat, fly_y_flat, fly_alive,
        output bullet_x_flat, bullet_y_flat, bullet_active_flat, shot_fired, fire_dropped
    );
endinterface

// File: rtl/player_bullet_controller.sv
// Player bullet pool: spawns on fire, moves bullets up once per movement tick and retires them
// at the top edge or on contact with a live fly. Define AUTOFIRE_EN for level-held autofire.
module player_bullet_controller #(
    parameter int BULLET_COUNT   = 8,
    parameter int FLY_COUNT      = 4,
    parameter int MOVE_DIV_BITS  = 16,
    parameter int BULLET_SPEED   = 4,
    parameter int COOLDOWN_TICKS = 6,
    parameter int PLAYER_W       = 32,
    parameter int FLY_SIZE       = 32
) (
    input  logic           clk25,
    input  logic           rst_n,
    player_bullet_if.slave bus
);
    localparam int              CD_W      = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN_TICKS);
    localparam logic [9:0]      SPEED     = 10'(BULLET_SPEED);
    localparam logic [9:0]      SPAWN_OFS = 10'(PLAYER_W / 2);
    localparam logic [10:0]     HIT_SIZE  = 11'(FLY_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPAWN,
        S_COOL
    } state_t;

    state_t                     state_q, state_d;
    logic                       fire_f1_q, fire_f2_q, fire_prev_q;
    logic [MOVE_DIV_BITS-1:0]   tick_cnt_q;
    logic [CD_W-1:0]            cooldown_q, cooldown_d, cooldown_dec;
    logic                       shot_fired_q, fire_dropped_q;
    logic                       tick, edge_req, fire_req, any_free, spawn, drop;
    logic [BULLET_COUNT-1:0]    active_vec, free_mask, spawn_onehot;
    logic [10*BULLET_COUNT-1:0] x_vec, y_vec;
    logic [9:0]                 spawn_x;

    assign tick     = &tick_cnt_q;
    assign edge_req = fire_f2_q & ~fire_prev_q;
`ifdef AUTOFIRE_EN
    assign fire_req = fire_f2_q;
`else
    assign fire_req = edge_req;
`endif

    // Free slots are judged on registered state, so a slot retired this cycle is reused next cycle.
    assign free_mask    = ~active_vec;
    assign any_free     = |free_mask;
    assign spawn_onehot = free_mask & (~free_mask + BULLET_COUNT'(1));
    assign spawn_x      = bus.player_x + SPAWN_OFS;

    assign cooldown_dec = (tick && cooldown_q != '0) ? cooldown_q - CD_W'(1) : cooldown_q;
    assign cooldown_d   = spawn ? CD_RELOAD : cooldown_dec;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            fire_f1_q      <= 1'b0;
            fire_f2_q      <= 1'b0;
            fire_prev_q    <= 1'b0;
            tick_cnt_q     <= '0;
            cooldown_q     <= '0;
            state_q        <= S_IDLE;
            shot_fired_q   <= 1'b0;
            fire_dropped_q <= 1'b0;
        end else begin
            fire_f1_q      <= bus.fire;
            fire_f2_q      <= fire_f1_q;
            fire_prev_q    <= fire_f2_q;
            tick_cnt_q     <= tick_cnt_q + MOVE_DIV_BITS'(1);
            cooldown_q     <= cooldown_d;
            state_q        <= state_d;
            shot_fired_q   <= spawn;
            fire_dropped_q <= drop;
        end
    end

    // A refusal is only reported for a fresh press; a held autofire level just waits.
    always_comb begin
        state_d = state_q;
        spawn   = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fire_req && cooldown_q == '0 && any_free) begin
                    spawn   = 1'b1;
                    state_d = S_SPAWN;
                end else if (edge_req) begin
                    drop = 1'b1;
                end
            end
            S_SPAWN, S_COOL: begin
                drop    = edge_req;
                state_d = (cooldown_dec == '0) ? S_IDLE : S_COOL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < BULLET_COUNT; gi++) begin : g_slot
            logic                 active_q, active_d;
            logic [9:0]           x_q, x_d, y_q, y_d;
            logic [FLY_COUNT-1:0] fly_hit;

            // 11-bit compares keep fx+FLY_SIZE from wrapping near the right/bottom edge.
            for (gj = 0; gj < FLY_COUNT; gj++) begin : g_fly
                logic [10:0] fx, fy, bx, by;
                assign fx = {1'b0, bus.fly_x_flat[gj*10 +: 10]};
                assign fy = {1'b0, bus.fly_y_flat[gj*10 +: 10]};
                assign bx = {1'b0, x_q};
                assign by = {1'b0, y_q};
                assign fly_hit[gj] = bus.fly_alive[gj]
                                   && (fx <= bx) && (bx < fx + HIT_SIZE)
                                   && (fy <= by) && (by < fy + HIT_SIZE);
            end

            always_comb begin
                active_d = active_q;
                x_d      = x_q;
                y_d      = y_q;
                if (spawn && spawn_onehot[gi]) begin
                    active_d = 1'b1;
                    x_d      = spawn_x;
                    y_d      = bus.player_y;
                end else if (tick && active_q) begin
                    if (|fly_hit) begin
                        active_d = 1'b0;
                    end else if (y_q < SPEED) begin
                        active_d = 1'b0;
                    end else begin
                        y_d = y_q - SPEED;
                    end
                end
            end

            always_ff @(posedge clk25 or negedge rst_n) begin
                if (!rst_n) begin
                    active_q <= 1'b0;
                    x_q      <= '0;
                    y_q      <= '0;
                end else begin
                    active_q <= active_d;
                    x_q      <= x_d;
                    y_q      <= y_d;
                end
            end

            assign active_vec[gi]      = active_q;
            assign x_vec[gi*10 +: 10]  = x_q;
            assign y_vec[gi*10 +: 10]  = y_q;
        end
    endgenerate

    assign bus.bullet_active_flat = active_vec;
    assign bus.bullet_x_flat      = x_vec;
    assign bus.bullet_y_flat      = y_vec;
    assign bus.shot_fired         = shot_fired_q;
    assign bus.fire_dropped       = fire_dropped_q;
endmodule

// File: tb/tb_player_bullet_controller.sv
// Scoreboard bench for player_bullet_controller: expected spawn/drop/retire/move events are
// queued as stimulus is issued and a negedge monitor pops and compares them.
module tb_player_bullet_controller;
    localparam int BC = 8;
    localparam int FC = 4;
    localparam int EV_SHOT   = 0;
    localparam int EV_DROP   = 1;
    localparam int EV_RETIRE = 2;
    localparam int EV_MOVE   = 3;

    typedef struct {
        int kind;
        int slot;
        int x;
        int y;
        int mask;
    } ev_t;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    ev_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   track_move = 1'b0;

    player_bullet_if #(.BULLET_COUNT(BC), .FLY_COUNT(FC)) bif ();

    player_bullet_controller #(
        .BULLET_COUNT(BC), .FLY_COUNT(FC), .MOVE_DIV_BITS(4), .BULLET_SPEED(4),
        .COOLDOWN_TICKS(2), .PLAYER_W(32), .FLY_SIZE(32)
    ) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .bus  (bif)
    );

    always #20 clk25 = ~clk25;

    function automatic void check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_SHOT:   return "shot";
            EV_DROP:   return "drop";
            EV_RETIRE: return "retire";
            default:   return "move";
        endcase
    endfunction

    task automatic push(input int kind, input int slot, input int x, input int y, input int mask);
        ev_t e;
        e.kind = kind; e.slot = slot; e.x = x; e.y = y; e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic consume(input int kind, input int slot, input int x, input int y, input int mask);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got slot=%0d x=%0d y=%0d expected no event", kname(kind), slot, x, y);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        if (kind != EV_DROP) check({kname(kind), "_slot"}, slot, e.slot);
        if (kind == EV_SHOT || kind == EV_RETIRE) check({kname(kind), "_x"}, x, e.x);
        if (kind != EV_DROP) check({kname(kind), "_y"}, y, e.y);
        if (kind != EV_MOVE) check({kname(kind), "_mask"}, mask, e.mask);
    endtask

    // Monitor: turns DUT output activity into events and pops the scoreboard.
    initial begin
        logic [BC-1:0] prev_act;
        logic [BC-1:0] act;
        logic [BC-1:0] newm;
        logic [9:0]    prev_y0;
        int            slot;
        prev_act = '0;
        prev_y0  = '0;
        forever begin
            @(negedge clk25);
            if (!rst_n) begin
                prev_act = '0;
                continue;
            end
            act = bif.bullet_active_flat;
            if (bif.shot_fired) begin
                newm = act & ~prev_act;
                slot = -1;
                for (int j = BC - 1; j >= 0; j--) if (newm[j]) slot = j;
                if (slot < 0) consume(EV_SHOT, -1, 0, 0, int'(act));
                else consume(EV_SHOT, slot, int'(bif.bullet_x_flat[slot*10 +: 10]),
                             int'(bif.bullet_y_flat[slot*10 +: 10]), int'(act));
            end
            if (bif.fire_dropped) consume(EV_DROP, -1, 0, 0, int'(act));
            for (int j = 0; j < BC; j++) begin
                if (prev_act[j] && !act[j])
                    consume(EV_RETIRE, j, int'(bif.bullet_x_flat[j*10 +: 10]),
                            int'(bif.bullet_y_flat[j*10 +: 10]), int'(act));
            end
            if (track_move && prev_act[0] && act[0] && bif.bullet_y_flat[9:0] != prev_y0)
                consume(EV_MOVE, 0, int'(bif.bullet_x_flat[9:0]), int'(bif.bullet_y_flat[9:0]), int'(act));
            prev_act = act;
            prev_y0  = bif.bullet_y_flat[9:0];
        end
    end

    task automatic fire_pulse();
        @(posedge clk25);
        #1 bif.fire = 1'b1;
        repeat (3) @(posedge clk25);
        #1 bif.fire = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk25);
            n++;
        end
        repeat (2) @(posedge clk25);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_fly(input int idx, input int x, input int y);
        bif.fly_x_flat[idx*10 +: 10] = 10'(x);
        bif.fly_y_flat[idx*10 +: 10] = 10'(y);
    endtask

    task automatic set_player(input int x, input int y);
        bif.player_x = 10'(x);
        bif.player_y = 10'(y);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_active"}, int'(bif.bullet_active_flat), 0);
        check({tag, "_x_any"}, int'(|bif.bullet_x_flat), 0);
        check({tag, "_y_any"}, int'(|bif.bullet_y_flat), 0);
        check({tag, "_shot"}, int'(bif.shot_fired), 0);
        check({tag, "_drop"}, int'(bif.fire_dropped), 0);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        bif.fire       = 1'b0;
        bif.player_x   = '0;
        bif.player_y   = '0;
        bif.fly_x_flat = '0;
        bif.fly_y_flat = '0;
        bif.fly_alive  = '0;
        repeat (3) @(posedge clk25);
        #1 check_zero("reset");
        @(negedge clk25);
        rst_n = 1'b1;
        repeat (4) @(posedge clk25);

        // Single bullet from (100,400) to the top edge; fly0 sits exactly one pixel short in x.
        set_player(100, 400);
        set_fly(0, 84, 200);
        bif.fly_alive = 4'b0001;
        track_move = 1'b1;
        push(EV_SHOT, 0, 116, 400, 1);
        for (int k = 1; k <= 100; k++) push(EV_MOVE, 0, 116, 400 - 4 * k, 1);
        push(EV_RETIRE, 0, 116, 0, 0);
        fire_pulse();
        wait_drain("top_edge", 2000);
        track_move = 1'b0;

        // Fill the pool, then a ninth request is refused.
        bif.fly_alive = 4'b0000;
        for (int j = 0; j < BC; j++) begin
            push(EV_SHOT, j, 116, 400, (1 << (j + 1)) - 1);
            fire_pulse();
            repeat (44) @(posedge clk25);
        end
        push(EV_DROP, -1, 0, 0, 255);
        fire_pulse();
        for (int j = 0; j < BC; j++) push(EV_RETIRE, j, 116, 0, (255 << (j + 1)) & 255);
        wait_drain("pool_full", 3000);
        repeat (48) @(posedge clk25);

        // Hit on live fly0 covering the spawn point.
        set_fly(0, 100, 300);
        bif.fly_alive = 4'b0001;
        set_player(100, 304);
        push(EV_SHOT, 0, 116, 304, 1);
        push(EV_RETIRE, 0, 116, 304, 0);
        fire_pulse();
        wait_drain("hit_fly0", 200);
        repeat (48) @(posedge clk25);

        // Hit on fly2 at the last pixel of its box in both axes.
        set_fly(2, 85, 273);
        bif.fly_alive = 4'b0100;
        push(EV_SHOT, 0, 116, 304, 1);
        push(EV_RETIRE, 0, 116, 304, 0);
        fire_pulse();
        wait_drain("hit_edge", 200);
        repeat (48) @(posedge clk25);

        // Miss: fly2 one pixel short in x, dead fly1 overlapping; bullet reaches the top.
        set_fly(2, 84, 273);
        set_fly(1, 100, 300);
        bif.fly_alive = 4'b0100;
        push(EV_SHOT, 0, 116, 304, 1);
        push(EV_RETIRE, 0, 116, 0, 0);
        fire_pulse();
        wait_drain("miss_edge", 1600);
        repeat (48) @(posedge clk25);

        // Two presses one tick apart; spawn x wraps at 10 bits.
        bif.fly_alive = 4'b0000;
        set_player(1015, 40);
        push(EV_SHOT, 0, 7, 40, 1);
        fire_pulse();
        repeat (12) @(posedge clk25);
        push(EV_DROP, -1, 0, 0, 1);
        fire_pulse();
        push(EV_RETIRE, 0, 7, 0, 0);
        wait_drain("cooldown", 400);
        repeat (48) @(posedge clk25);

        // Held fire.
        set_player(100, 400);
`ifdef AUTOFIRE_EN
        push(EV_SHOT, 0, 116, 400, 1);
        push(EV_SHOT, 1, 116, 400, 3);
        push(EV_SHOT, 2, 116, 400, 7);
        @(posedge clk25);
        #1 bif.fire = 1'b1;
        wait_drain("autofire", 200);
        #1 bif.fire = 1'b0;
        push(EV_RETIRE, 0, 116, 0, 6);
        push(EV_RETIRE, 1, 116, 0, 4);
        push(EV_RETIRE, 2, 116, 0, 0);
        wait_drain("autofire_retire", 2000);
`else
        push(EV_SHOT, 0, 116, 400, 1);
        @(posedge clk25);
        #1 bif.fire = 1'b1;
        repeat (320) @(posedge clk25);
        #1 bif.fire = 1'b0;
        push(EV_RETIRE, 0, 116, 0, 0);
        wait_drain("hold", 2000);
`endif
        repeat (48) @(posedge clk25);

        // Asynchronous reset in mid-flight clears outputs immediately.
        push(EV_SHOT, 0, 116, 400, 1);
        fire_pulse();
        wait_drain("pre_reset", 100);
        repeat (40) @(posedge clk25);
        check("pre_reset_active", int'(bif.bullet_active_flat), 1);
        #5 rst_n = 1'b0;
        #1 check_zero("midreset");
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        rst_n = 1'b1;
        repeat (20) @(posedge clk25);
        #1 check("post_reset_active", int'(bif.bullet_active_flat), 0);

        check("leftover_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
